uart_ctrl: RTL
==============

// Module: uart_ctrl
// PURPOSE
//  Parametrised full-duplex UART. Successor to the fixed 8E1 UART.
//  Frame format and FIFO depth are set per instance: 5-8 data bits, none/even/odd parity, 1-2 stop bits.
//  Adds an Rx synchroniser, false-start rejection, and sticky parity/frame/overrun error flags.
//  Sits between the CPU memory-mapped I/O port and the board pins Tx/Rx.
// PARAMETERS
//  CLOCKRATE    100000000  system clock, Hz
//  BAUDRATE     9600       line rate; DIV = CLOCKRATE/BAUDRATE clocks per bit, DIV >= 4
//  DATA_BITS    8          data bits per frame, 5..8, sent LSB first
//  PARITY       1          0 none, 1 even, 2 odd
//  STOP_BITS    1          1 or 2
//  FIFO_AW      4          FIFO address width; depth = 2**FIFO_AW for both Tx and Rx FIFOs
// PORTS
//  CLK          in   1          system clock, posedge
//  RST_N        in   1          async active-low reset
//  send_flag    in   1          push send_data into Tx FIFO; ignored while sendable=0
//  send_data    in   DATA_BITS  byte to transmit
//  recv_flag    in   1          pop Rx FIFO head; ignored while receivable=0
//  recv_data    out  DATA_BITS  Rx FIFO head (first-word fall-through), valid while receivable=1
//  sendable     out  1          Tx FIFO not full
//  receivable   out  1          Rx FIFO not empty
//  tx_busy      out  1          Tx FSM not IDLE, or Tx FIFO non-empty
//  err_parity   out  1          sticky: frame received with bad parity
//  err_frame    out  1          sticky: stop bit sampled low
//  err_overrun  out  1          sticky: good frame dropped because Rx FIFO was full
//  err_clear    in   1          clears all three sticky flags; a set in the same cycle wins
//  Tx           out  1          serial out, idle high
//  Rx           in   1          serial in, asynchronous to CLK
// BEHAVIOUR
//  Reset (RST_N=0, takes effect immediately, mid-frame included):
//   Tx=1; both FIFOs empty, so sendable=1 and receivable=0; error flags 0; FSMs in IDLE; recv_data=0.
//  Rx path: Rx passes through a 2-FF synchroniser before any use; the synchronised value is rx_s.
//  Rx FSM states: IDLE -> START -> DATA -> PAR -> STOP -> IDLE.
//   IDLE: on rx_s=0, go to START and load the bit counter.
//   START: at DIV/2, rx_s=1 means a glitch -> back to IDLE, no push, no flag.
//   DATA/PAR/STOP: one sample every DIV clocks, centred mid-bit. PAR state is skipped when PARITY=0.
//   Parity check: even means XOR(data,parity bit)=0; odd means XOR=1. Mismatch sets err_parity, byte dropped.
//   Stop bit: only the first stop bit is checked on Rx. A low stop bit sets err_frame, byte dropped.
//   After STOP the FSM returns to IDLE immediately, so a new start edge is accepted at once.
//   Good frame with Rx FIFO full: set err_overrun, byte dropped, existing contents untouched.
//   Good frame otherwise: pushed one clock after the stop-bit sample.
//  Tx FSM states: IDLE -> START -> DATA -> PAR -> STOP -> IDLE; each bit lasts exactly DIV clocks.
//   Bit timer restarts on leaving IDLE (not free-running).
//   IDLE with Tx FIFO non-empty: pop the head into the shift register and drive Tx=0.
//   Latency: send_flag sampled at edge n gives Tx=0 after edge n+2 (FIFO empty, FSM IDLE).
//   STOP drives 1 for STOP_BITS*DIV clocks. Back-to-back frames have no extra idle gap.
//  FIFO rules, both FIFOs:
//   push on full is rejected, even if a pop happens in the same cycle;
//   pop on empty is ignored; simultaneous push and pop when not full/empty keeps the count unchanged;
//   pointers wrap modulo depth; one extra pointer bit distinguishes full from empty.
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined: each Rx sample is the majority of rx_s at DIV/2-1, DIV/2 and DIV/2+1.
//   This applies to start confirmation too.
//  Undefined: single sample at DIV/2. Frame timing is identical either way.
// STRUCTURE
//  uart_pkg: Rx/Tx state encodings, PARITY_NONE/EVEN/ODD constants, DIV computation, width checks.
//  Sub-module uart_fifo (WIDTH, AW): sync FWFT FIFO with full/empty; instantiated as tx_fifo and rx_fifo.
//  Rx FSM, Tx FSM and error flags stay in uart_ctrl.
// TESTING  (CLOCKRATE=16, BAUDRATE=1 -> DIV=16; Tx looped to Rx unless stated)
//  1. 8E1, send 0xA5 -> Tx bits 0,1,0,1,0,0,1,0,1,0(par),1 at 16 clk/bit;
//     then receivable=1, recv_data=0xA5, no error flags.
//  2. PARITY=2, DATA_BITS=7, STOP_BITS=2, send 0x41 -> parity bit 1, stop high 32 clk; recv_data=0x41.
//  3. Bench drives an 8E1 frame of 0x3C with the stop bit low -> no push, err_frame=1;
//     err_clear -> 0.
//  4. Bench drives 17 frames without popping, FIFO_AW=4 -> 16 stored in order, 17th dropped,
//     err_overrun=1.
//  5. Rx low for 4 clocks then high -> stays IDLE, receivable=0, no flags;
//     repeat with UART_RX_MAJORITY_EN, same result.
//  6. RST_N low mid-data-bit of a Tx frame -> Tx=1 immediately, sendable=1;
//     after release, a new 0x5A is sent correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM encodings, parity modes,
// bit-period computation and parameter sanity checks.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  function automatic int unsigned calc_div(input int unsigned clockrate,
                                           input int unsigned baudrate);
    return clockrate / baudrate;
  endfunction

  function automatic bit params_ok(input int unsigned div,
                                   input int unsigned data_bits,
                                   input int unsigned parity,
                                   input int unsigned stop_bits,
                                   input int unsigned fifo_aw);
    return (div >= 4) && (data_bits >= 5) && (data_bits <= 8) &&
           (parity <= PARITY_ODD) && (stop_bits >= 1) && (stop_bits <= 2) &&
           (fifo_aw >= 1);
  endfunction

  // Parity bit to transmit / expect for zero-extended data.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input int unsigned parity);
    logic p;
    p = 1'b0;
    if (parity == PARITY_EVEN) p = ^data;
    else if (parity == PARITY_ODD) p = ~^data;
    return p;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word-fall-through FIFO, depth 2**AW, with full/empty.
// Push on full is rejected; pop on empty is ignored.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/uart_ctrl.sv
// Parametrised full-duplex UART with Tx/Rx FIFOs and sticky error flags.
// Define UART_RX_MAJORITY_EN for 3-tap majority voting of each Rx sample.
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKRATE = 100000000,
  parameter int unsigned BAUDRATE  = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 1,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_AW   = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 send_flag,
  input  logic [DATA_BITS-1:0] send_data,
  input  logic                 recv_flag,
  output logic [DATA_BITS-1:0] recv_data,
  output logic                 sendable,
  output logic                 receivable,
  output logic                 tx_busy,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 err_overrun,
  input  logic                 err_clear,
  output logic                 Tx,
  input  logic                 Rx
);

  localparam int unsigned DIV = calc_div(CLOCKRATE, BAUDRATE);
  localparam int unsigned CW  = $clog2(STOP_BITS * DIV + 1);
  localparam int unsigned BW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] RX_HALF  = CW'(DIV / 2 + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (!params_ok(DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_AW)) begin : g_bad_params
    $error("uart_ctrl: unsupported parameter set");
  end

  logic                 tx_pop;
  logic [DATA_BITS-1:0] tx_head;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 rx_push_q;
  logic                 rx_full;
  logic                 rx_empty;
  logic [DATA_BITS-1:0] rx_shift;

  uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) tx_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (send_flag),
    .push_data (send_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  uart_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) rx_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .push      (rx_push_q),
    .push_data (rx_shift),
    .pop       (recv_flag),
    .pop_data  (recv_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign sendable   = !tx_full;
  assign receivable = !rx_empty;

  // ---------------- Rx synchroniser and sampling ----------------
  logic rx_meta;
  logic rx_s;
  logic rx_bit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // Decisions are made at DIV/2+1 in both builds so frame timing is identical.
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rx_hist <= '1;
    else        rx_hist <= {rx_hist[0], rx_s};
  end
  assign rx_bit = (rx_hist[1] & rx_hist[0]) | ((rx_hist[1] | rx_hist[0]) & rx_s);
`else
  logic rx_hist;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rx_hist <= 1'b1;
    else        rx_hist <= rx_s;
  end
  assign rx_bit = rx_hist;
`endif

  // ---------------- Rx FSM ----------------
  rx_state_t            rx_state, rx_state_n;
  logic [CW-1:0]        rx_cnt, rx_cnt_n;
  logic [BW-1:0]        rx_bitn, rx_bitn_n;
  logic [DATA_BITS-1:0] rx_shift_n;
  logic                 rx_par_bad, rx_par_bad_n;
  logic                 rx_push_n;
  logic                 set_parity;
  logic                 set_frame;
  logic                 set_overrun;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bitn    <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bitn    <= rx_bitn_n;
      rx_shift   <= rx_shift_n;
      rx_par_bad <= rx_par_bad_n;
      rx_push_q  <= rx_push_n;
    end
  end

  always_comb begin
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt;
    rx_bitn_n    = rx_bitn;
    rx_shift_n   = rx_shift;
    rx_par_bad_n = rx_par_bad;
    rx_push_n    = 1'b0;
    set_parity   = 1'b0;
    set_frame    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_n = RX_START;
          rx_cnt_n   = CNT_ONE;
        end
      end
      RX_START: begin
        rx_cnt_n = rx_cnt + CNT_ONE;
        if (rx_cnt == RX_HALF) begin
          rx_cnt_n = '0;
          if (rx_bit) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n   = RX_DATA;
            rx_bitn_n    = '0;
            rx_par_bad_n = 1'b0;
          end
        end
      end
      RX_DATA: begin
        rx_cnt_n = rx_cnt + CNT_ONE;
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_bit, rx_shift[DATA_BITS-1:1]};
          rx_bitn_n  = rx_bitn + BIT_ONE;
          if (rx_bitn == LAST_BIT)
            rx_state_n = (PARITY == PARITY_NONE) ? RX_STOP : RX_PAR;
        end
      end
      RX_PAR: begin
        rx_cnt_n = rx_cnt + CNT_ONE;
        if (rx_cnt == BIT_END) begin
          rx_cnt_n     = '0;
          rx_par_bad_n = (rx_bit != parity_bit(8'(rx_shift), PARITY));
          rx_state_n   = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_n = rx_cnt + CNT_ONE;
        if (rx_cnt == BIT_END) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          set_parity = rx_par_bad;
          set_frame  = !rx_bit;
          rx_push_n  = !rx_par_bad && rx_bit;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign set_overrun = rx_push_q && rx_full;

  // ---------------- Sticky error flags ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_parity  <= set_parity  | (err_parity  & ~err_clear);
      err_frame   <= set_frame   | (err_frame   & ~err_clear);
      err_overrun <= set_overrun | (err_overrun & ~err_clear);
    end
  end

  // ---------------- Tx FSM ----------------
  tx_state_t            tx_state, tx_state_n;
  logic [CW-1:0]        tx_cnt, tx_cnt_n;
  logic [BW-1:0]        tx_bitn, tx_bitn_n;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line;
  logic                 tx_load;
  logic                 tx_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bitn  <= tx_bitn_n;
      tx_shift <= tx_shift_n;
      tx_par   <= tx_par_n;
      tx_q     <= tx_line;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bitn_n  = tx_bitn;
    tx_shift_n = tx_shift;
    tx_par_n   = tx_par;
    tx_line    = 1'b1;
    tx_load    = 1'b0;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_load = !tx_empty;
      end
      TX_START: begin
        tx_line  = 1'b0;
        tx_cnt_n = tx_cnt + CNT_ONE;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_bitn_n  = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line  = tx_shift[0];
        tx_cnt_n = tx_cnt + CNT_ONE;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_shift_n = {1'b0, tx_shift[DATA_BITS-1:1]};
          tx_bitn_n  = tx_bitn + BIT_ONE;
          if (tx_bitn == LAST_BIT)
            tx_state_n = (PARITY == PARITY_NONE) ? TX_STOP : TX_PAR;
        end
      end
      TX_PAR: begin
        tx_line  = tx_par;
        tx_cnt_n = tx_cnt + CNT_ONE;
        if (tx_cnt == BIT_END) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_cnt_n = tx_cnt + CNT_ONE;
        if (tx_cnt == STOP_END) begin
          tx_cnt_n   = '0;
          tx_state_n = TX_IDLE;
          tx_load    = !tx_empty;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // Loading straight from STOP lets back-to-back frames run without an idle gap.
    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_shift_n = tx_head;
      tx_par_n   = parity_bit(8'(tx_head), PARITY);
      tx_cnt_n   = '0;
      tx_bitn_n  = '0;
      tx_state_n = TX_START;
    end
  end

  assign Tx      = tx_q;
  assign tx_busy = (tx_state != TX_IDLE) || !tx_empty;

endmodule
